// File: rtl/abs_diff_line_sync.sv
// Sub-pel SAD front end: five vertical phases x {integer, half, quarter} horizontal phases,
// absolute differences against the original row, one register stage. ABS_DIFF_LINE_INPUT_REG_EN adds an input register.
package abs_diff_line_sync_pkg;
  // (a+b+1)>>1
  function automatic logic [7:0] avg2(input logic [7:0] a, input logic [7:0] b);
    logic [9:0] s;
    s = {2'b0, a} + {2'b0, b} + 10'd1;
    return s[8:1];
  endfunction

  // (3a+b+2)>>2; the 10-bit sum tops out at 1022
  function automatic logic [7:0] avg31(input logic [7:0] a, input logic [7:0] b);
    logic [9:0] s;
    s = {2'b0, a} + {1'b0, a, 1'b0} + {2'b0, b} + 10'd2;
    return s[9:2];
  endfunction

  function automatic logic [7:0] absd(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction
endpackage

module abs_diff_line_sync_phase
  import abs_diff_line_sync_pkg::*;
(
  input  logic [63:0]  v_i,
  input  logic [63:0]  org_i,
  output logic [55:0]  f_o,
  output logic [111:0] h_o,
  output logic [111:0] q_o
);
  for (genvar k = 0; k < 7; k++) begin : g_k
    logic [7:0] vk, vk1, ok, ok1, half, ql, qr;
    assign vk   = v_i[8*k +: 8];
    assign vk1  = v_i[8*(k+1) +: 8];
    assign ok   = org_i[8*k +: 8];
    assign ok1  = org_i[8*(k+1) +: 8];
    assign half = avg2(vk, vk1);
    assign ql   = avg31(vk, vk1);
    assign qr   = avg31(vk1, vk);
    assign f_o[8*k +: 8]      = absd(vk, ok);
    assign h_o[16*k +: 8]     = absd(half, ok);
    assign h_o[16*k+8 +: 8]   = absd(half, ok1);
    assign q_o[16*k +: 8]     = absd(ql, ok);
    assign q_o[16*k+8 +: 8]   = absd(qr, ok1);
  end
endmodule

module abs_diff_line_sync
  import abs_diff_line_sync_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [63:0]  cur_upper_pix,
  input  logic [63:0]  cur_middle_pix,
  input  logic [63:0]  cur_lower_pix,
  input  logic [63:0]  org_pix,
  output logic         out_valid,
  output logic [111:0] diff_UH_h, diff_UQ_h, diff_M_h, diff_LQ_h, diff_LH_h,
  output logic [111:0] diff_UH_q, diff_UQ_q, diff_M_q, diff_LQ_q, diff_LH_q,
  output logic [55:0]  diff_UH_f, diff_UQ_f, diff_M_f, diff_LQ_f, diff_LH_f
);
  logic        vld;
  logic [63:0] up, mid, lo, org;

`ifdef ABS_DIFF_LINE_INPUT_REG_EN
  logic        vld_q;
  logic [63:0] up_q, mid_q, lo_q, org_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      up_q  <= '0;
      mid_q <= '0;
      lo_q  <= '0;
      org_q <= '0;
    end else begin
      vld_q <= in_valid;
      up_q  <= cur_upper_pix;
      mid_q <= cur_middle_pix;
      lo_q  <= cur_lower_pix;
      org_q <= org_pix;
    end
  end
  assign vld = vld_q;
  assign up  = up_q;
  assign mid = mid_q;
  assign lo  = lo_q;
  assign org = org_q;
`else
  assign vld = in_valid;
  assign up  = cur_upper_pix;
  assign mid = cur_middle_pix;
  assign lo  = cur_lower_pix;
  assign org = org_pix;
`endif

  // vertical phase order: 0=UH 1=UQ 2=M 3=LQ 4=LH
  logic [4:0][63:0] vrow;
  for (genvar i = 0; i < 8; i++) begin : g_pix
    logic [7:0] u, m, l;
    assign u = up[8*i +: 8];
    assign m = mid[8*i +: 8];
    assign l = lo[8*i +: 8];
    assign vrow[0][8*i +: 8] = avg2(u, m);
    assign vrow[1][8*i +: 8] = avg31(m, u);
    assign vrow[2][8*i +: 8] = m;
    assign vrow[3][8*i +: 8] = avg31(m, l);
    assign vrow[4][8*i +: 8] = avg2(m, l);
  end

  logic [4:0][55:0]  f_d, f_q;
  logic [4:0][111:0] h_d, h_q, q_d, q_q;
  logic              out_valid_q;

  for (genvar p = 0; p < 5; p++) begin : g_phase
    abs_diff_line_sync_phase u_phase (
      .v_i  (vrow[p]),
      .org_i(org),
      .f_o  (f_d[p]),
      .h_o  (h_d[p]),
      .q_o  (q_d[p])
    );
  end

  // diffs hold across idle cycles; only out_valid drops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      f_q         <= '0;
      h_q         <= '0;
      q_q         <= '0;
    end else begin
      out_valid_q <= vld;
      if (vld) begin
        f_q <= f_d;
        h_q <= h_d;
        q_q <= q_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign diff_UH_f = f_q[0];
  assign diff_UQ_f = f_q[1];
  assign diff_M_f  = f_q[2];
  assign diff_LQ_f = f_q[3];
  assign diff_LH_f = f_q[4];
  assign diff_UH_h = h_q[0];
  assign diff_UQ_h = h_q[1];
  assign diff_M_h  = h_q[2];
  assign diff_LQ_h = h_q[3];
  assign diff_LH_h = h_q[4];
  assign diff_UH_q = q_q[0];
  assign diff_UQ_q = q_q[1];
  assign diff_M_q  = q_q[2];
  assign diff_LQ_q = q_q[3];
  assign diff_LH_q = q_q[4];
endmodule

// File: tb/tb_abs_diff_line_sync.sv
// Directed bench for abs_diff_line_sync; expected values are hand-computed byte patterns per phase.
module tb_abs_diff_line_sync;
`ifdef ABS_DIFF_LINE_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [63:0]  up = '0, mid = '0, lo = '0, org = '0;
  logic         out_valid;
  logic [111:0] UH_h, UQ_h, M_h, LQ_h, LH_h;
  logic [111:0] UH_q, UQ_q, M_q, LQ_q, LH_q;
  logic [55:0]  UH_f, UQ_f, M_f, LQ_f, LH_f;

  abs_diff_line_sync dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .cur_upper_pix(up), .cur_middle_pix(mid), .cur_lower_pix(lo), .org_pix(org),
    .out_valid(out_valid),
    .diff_UH_h(UH_h), .diff_UQ_h(UQ_h), .diff_M_h(M_h), .diff_LQ_h(LQ_h), .diff_LH_h(LH_h),
    .diff_UH_q(UH_q), .diff_UQ_q(UQ_q), .diff_M_q(M_q), .diff_LQ_q(LQ_q), .diff_LH_q(LH_q),
    .diff_UH_f(UH_f), .diff_UQ_f(UQ_f), .diff_M_f(M_f), .diff_LQ_f(LQ_f), .diff_LH_f(LH_f)
  );

  always #5 clk = ~clk;

  logic [4:0][111:0] gh, gq;
  logic [4:0][55:0]  gf;
  assign gh = {LH_h, LQ_h, M_h, UQ_h, UH_h};
  assign gq = {LH_q, LQ_q, M_q, UQ_q, UH_q};
  assign gf = {LH_f, LQ_f, M_f, UQ_f, UH_f};

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [111:0] got, input logic [111:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // every element of a phase's f/h/q bus equals one byte
  task automatic check_uni(input string tag, input logic ev,
                           input logic [4:0][7:0] ef, input logic [4:0][7:0] eh,
                           input logic [4:0][7:0] eq);
    chk({tag, "_vld"}, {111'b0, out_valid}, {111'b0, ev});
    for (int p = 0; p < 5; p++) begin
      chk($sformatf("%s_p%0d_f", tag, p), {56'b0, gf[p]}, {56'b0, {7{ef[p]}}});
      chk($sformatf("%s_p%0d_h", tag, p), gh[p], {14{eh[p]}});
      chk($sformatf("%s_p%0d_q", tag, p), gq[p], {14{eq[p]}});
    end
  endtask

  task automatic drive(input logic [63:0] u, input logic [63:0] m,
                       input logic [63:0] l, input logic [63:0] o);
    in_valid = 1'b1;
    up = u; mid = m; lo = l; org = o;
  endtask

  function automatic logic [63:0] rep8(input logic [7:0] b);
    return {8{b}};
  endfunction

  logic [63:0]      ramp;
  logic [7:0]       sa [4];
  logic [7:0]       sb [4];
  logic [7:0]       sd [4];
  logic [4:0][7:0]  e;

  initial begin
    sa = '{8'h10, 8'h90, 8'h05, 8'hF0};
    sb = '{8'h30, 8'h10, 8'h06, 8'h0F};
    sd = '{8'h20, 8'h80, 8'h01, 8'hE1};
    for (int k = 0; k < 8; k++) ramp[8*k +: 8] = 8'(16 * k);

    #12;
    check_uni("reset", 1'b0, '0, '0, '0);
    @(negedge clk) rst = 1'b0;

    drive(rep8(8'h40), rep8(8'h40), rep8(8'h40), rep8(8'h40));
    repeat (LAT) @(negedge clk);
    check_uni("flat40", 1'b1, '0, '0, '0);

    drive(rep8(8'h00), rep8(8'h80), rep8(8'hFF), rep8(8'h80));
    repeat (LAT) @(negedge clk);
    e = {8'h40, 8'h20, 8'h00, 8'h20, 8'h40};
    check_uni("vert", 1'b1, e, e, e);

    drive(ramp, ramp, ramp, ramp);
    repeat (LAT) @(negedge clk);
    check_uni("ramp", 1'b1, '0, {5{8'h08}}, {5{8'h04}});

    // round-half-up: truncation would give 1,1,2,1,1
    drive(rep8(8'h01), rep8(8'h02), rep8(8'h00), rep8(8'h00));
    repeat (LAT) @(negedge clk);
    e = {8'h01, 8'h02, 8'h02, 8'h02, 8'h02};
    check_uni("round", 1'b1, e, e, e);

    drive(rep8(8'hFF), rep8(8'hFF), rep8(8'hFF), rep8(8'h00));
    repeat (LAT) @(negedge clk);
    check_uni("maxpos", 1'b1, {5{8'hFF}}, {5{8'hFF}}, {5{8'hFF}});

    drive(rep8(8'h00), rep8(8'h00), rep8(8'h00), rep8(8'hFF));
    repeat (LAT) @(negedge clk);
    check_uni("maxneg", 1'b1, {5{8'hFF}}, {5{8'hFF}}, {5{8'hFF}});

    // back-to-back stream, then idle: results in order, then hold
    for (int cyc = 0; cyc <= 3 + LAT; cyc++) begin
      if (cyc >= LAT) begin
        e = {5{sd[cyc-LAT]}};
        check_uni($sformatf("stream%0d", cyc - LAT), 1'b1, e, e, e);
      end
      if (cyc < 4) drive(rep8(sa[cyc]), rep8(sa[cyc]), rep8(sa[cyc]), rep8(sb[cyc]));
      else in_valid = 1'b0;
      @(negedge clk);
    end
    e = {5{sd[3]}};
    check_uni("hold", 1'b0, e, e, e);

    // async reset mid-stream
    drive(rep8(8'h10), rep8(8'h10), rep8(8'h10), rep8(8'h30));
    repeat (LAT) @(negedge clk);
    check_uni("prerst", 1'b1, {5{8'h20}}, {5{8'h20}}, {5{8'h20}});
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_uni("asyncrst", 1'b0, '0, '0, '0);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check_uni("postrst", 1'b0, '0, '0, '0);
    drive(rep8(8'h90), rep8(8'h90), rep8(8'h90), rep8(8'h10));
    repeat (LAT) @(negedge clk);
    check_uni("firstvld", 1'b1, {5{8'h80}}, {5{8'h80}}, {5{8'h80}});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
